viterbi_traceback: RTL and testbench

Survivor-path memory and traceback stage of the 4-state (K=3, rate-1/2) Viterbi decoder. It sits directly downstream of the add-compare-select units. Per trellis step it stores the four ACS decision bits, one per state. At frame end it traces back from the minimum-metric state and emits the decoded bits in transmission order over a valid/ready stream.

---
 rtl/viterbi_pkg.sv | 25 ++
 rtl/pm_argmin4.sv | 25 ++
 rtl/viterbi_traceback.sv | 150 +++++++++++++++
 tb/tb_viterbi_traceback.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared definitions for the 4-state (K=3, rate-1/2) Viterbi decoder.
//   NUM_STATES / STATE_W : trellis size and state-index width
//   PM_W                 : default path-metric width
//   vtb_state_e          : traceback FSM states
//   pred_state()         : survivor predecessor of state s given that step's decision bits
package viterbi_pkg;

   localparam int unsigned NUM_STATES = 4;
   localparam int unsigned STATE_W    = 2;
   localparam int unsigned PM_W       = 4;

   typedef enum logic [1:0] {
      StWrite,
      StTrace,
      StOutput
   } vtb_state_e;

   // s[1] is the newest input bit, so the predecessor shifts s[0] up and
   // takes the state's own decision bit as the older bit.
   function automatic logic [STATE_W-1:0] pred_state(input logic [STATE_W-1:0]    s,
                                                      input logic [NUM_STATES-1:0] d);
      return {s[0], d[s]};
   endfunction

endpackage

// File: rtl/pm_argmin4.sv
// pm_argmin4: combinational index of the smallest of four unsigned path metrics.
//   pm_i   : packed metrics, pm_k = pm_i[PM_W*k +: PM_W]
//   best_o : index of the minimum; ties resolve to the lowest index
module pm_argmin4 #(
   parameter int unsigned PM_W = 4
) (
   input  logic [4*PM_W-1:0] pm_i,
   output logic [1:0]        best_o
);
   import viterbi_pkg::*;

   logic [PM_W-1:0] pm [NUM_STATES];
   logic [1:0]      lo_idx;
   logic [1:0]      hi_idx;

   for (genvar i = 0; i < NUM_STATES; i++) begin : g_unpack
      assign pm[i] = pm_i[PM_W*i +: PM_W];
   end

   // Strict less-than at every level keeps the lower index on ties.
   assign lo_idx = (pm[1] < pm[0]) ? 2'd1 : 2'd0;
   assign hi_idx = (pm[3] < pm[2]) ? 2'd3 : 2'd2;
   assign best_o = (pm[hi_idx] < pm[lo_idx]) ? hi_idx : lo_idx;

endmodule

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: survivor memory and traceback for the 4-state Viterbi decoder.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   dec_valid_i       : ACS decision vector valid
//   dec_bits_i        : one decision bit per state
//   dec_last_i        : final trellis step of the frame
//   final_pm_i        : final path metrics, sampled with the accepted last step
//   dec_ready_o       : decisions accepted (WRITE state)
//   bit_valid_o/bit_out_o/bit_last_o/bit_ready_i : decoded-bit stream, transmission order
//   overrun_o         : pulse when a decision vector arrived while not ready (dropped)
module viterbi_traceback #(
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned PM_W      = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dec_valid_i,
   input  logic [3:0]        dec_bits_i,
   input  logic              dec_last_i,
   input  logic [4*PM_W-1:0] final_pm_i,
   output logic              dec_ready_o,
   output logic              bit_valid_o,
   output logic              bit_out_o,
   output logic              bit_last_o,
   input  logic              bit_ready_i,
   output logic              overrun_o
);
   import viterbi_pkg::*;

   localparam int unsigned PTR_W = $clog2(FRAME_LEN);
   typedef logic [PTR_W-1:0] ptr_t;
   localparam ptr_t PTR_MAX = ptr_t'(FRAME_LEN - 1);

   vtb_state_e         state_q, state_d;
   // One pointer serves as write, trace and read index in turn.
   ptr_t               ptr_q, ptr_d;
   ptr_t               ptr_inc;
   ptr_t               last_q, last_d;
   logic [STATE_W-1:0] cur_q, cur_d;
   logic [STATE_W-1:0] best;
   logic               bit_valid_q, bit_valid_d;
   logic               bit_out_q, bit_out_d;
   logic               bit_last_q, bit_last_d;
   logic               overrun_q, overrun_d;
   logic               mem_we, lifo_we;

   logic [NUM_STATES-1:0] mem_q [FRAME_LEN];
   logic [FRAME_LEN-1:0]  lifo_q;

   pm_argmin4 #(.PM_W(PM_W)) u_argmin (
      .pm_i   (final_pm_i),
      .best_o (best)
   );

   assign ptr_inc = ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      cur_d       = cur_q;
      bit_valid_d = bit_valid_q;
      bit_out_d   = bit_out_q;
      bit_last_d  = bit_last_q;
      overrun_d   = dec_valid_i & (state_q != StWrite);
      mem_we      = 1'b0;
      lifo_we     = 1'b0;
      case (state_q)
         StWrite: begin
            if (dec_valid_i) begin
               mem_we = 1'b1;
               if (dec_last_i || (ptr_q == PTR_MAX)) begin
                  // Pointer stays on the last step: traceback starts there.
                  last_d  = ptr_q;
                  cur_d   = best;
                  state_d = StTrace;
               end else begin
                  ptr_d = ptr_inc;
               end
            end
         end
         StTrace: begin
            lifo_we = 1'b1;
            cur_d   = pred_state(cur_q, mem_q[ptr_q]);
            if (ptr_q == '0) begin
               state_d     = StOutput;
               bit_valid_d = 1'b1;
               bit_out_d   = cur_q[1];
               bit_last_d  = (last_q == '0);
            end else begin
               ptr_d = ptr_q - 1'b1;
            end
         end
         StOutput: begin
            if (bit_ready_i) begin
               if (ptr_q == last_q) begin
                  state_d     = StWrite;
                  ptr_d       = '0;
                  bit_valid_d = 1'b0;
                  bit_out_d   = 1'b0;
                  bit_last_d  = 1'b0;
               end else begin
                  ptr_d      = ptr_inc;
                  bit_out_d  = lifo_q[ptr_inc];
                  bit_last_d = (ptr_inc == last_q);
               end
            end
         end
         default: state_d = StWrite;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StWrite;
         ptr_q       <= '0;
         last_q      <= '0;
         cur_q       <= '0;
         bit_valid_q <= 1'b0;
         bit_out_q   <= 1'b0;
         bit_last_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         cur_q       <= cur_d;
         bit_valid_q <= bit_valid_d;
         bit_out_q   <= bit_out_d;
         bit_last_q  <= bit_last_d;
         overrun_q   <= overrun_d;
      end
   end

   // Storage arrays carry no reset; the pointers alone define their contents.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[ptr_q] <= dec_bits_i;
      end
      if (lifo_we) begin
         lifo_q[ptr_q] <= cur_q[1];
      end
   end

   assign dec_ready_o = (state_q == StWrite);
   assign bit_valid_o = bit_valid_q;
   assign bit_out_o   = bit_out_q;
   assign bit_last_o  = bit_last_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: self-checking bench for viterbi_traceback.
// Fixed frames come from a vector table; random frames are produced by running a
// K=3 encoder forward, planting the survivor decisions along the true path, and
// expecting the encoder input bits back.
module tb_viterbi_traceback;
   localparam int unsigned FRAME_LEN = 16;
   localparam int unsigned PM_W      = 4;

   logic              clock;
   logic              reset;
   logic              dec_valid;
   logic [3:0]        dec_bits;
   logic              dec_last;
   logic [4*PM_W-1:0] final_pm;
   logic              dec_ready;
   logic              bit_valid;
   logic              bit_out;
   logic              bit_last;
   logic              bit_ready;
   logic              overrun;

   int n_vec;
   int n_err;
   int cyc;

   logic [3:0] dec_buf [FRAME_LEN];
   logic       exp_buf [FRAME_LEN];

   typedef struct {
      int          n;
      logic [15:0] pm;
      logic [15:0] dec_word;  // step i decisions at [4*i +: 4]
      logic [3:0]  exp_bits;  // expected decoded bit i at [i]
   } vec_t;

   vec_t tbl [5];

   viterbi_traceback #(.FRAME_LEN(FRAME_LEN), .PM_W(PM_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .dec_valid_i (dec_valid),
      .dec_bits_i  (dec_bits),
      .dec_last_i  (dec_last),
      .final_pm_i  (final_pm),
      .dec_ready_o (dec_ready),
      .bit_valid_o (bit_valid),
      .bit_out_o   (bit_out),
      .bit_last_o  (bit_last),
      .bit_ready_i (bit_ready),
      .overrun_o   (overrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic load_entry(input int idx);
      for (int i = 0; i < tbl[idx].n; i++) begin
         dec_buf[i] = tbl[idx].dec_word[4*i +: 4];
         exp_buf[i] = tbl[idx].exp_bits[i];
      end
   endtask

   // Encoder path s_i = {u_i, u_(i-1)}; predecessor {u_(i-1), u_(i-2)} needs d = u_(i-2).
   task automatic build_random(input int n, input bit end_zero, output logic [15:0] pm_word);
      logic       u [FRAME_LEN];
      logic [1:0] s;
      logic [3:0] d;
      int         pmv [4];
      int         v;
      s = 2'b00;
      for (int i = 0; i < n; i++) begin
         u[i] = 1'($urandom_range(0, 1));
         if (end_zero && (i >= n - 2)) u[i] = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         s[1] = u[i];
         s[0] = 1'b0;
         if (i >= 1) s[0] = u[i-1];
         d = 4'($urandom);
         d[s] = 1'b0;
         if (i >= 2) d[s] = u[i-2];
         dec_buf[i] = d;
         exp_buf[i] = u[i];
      end
      if (end_zero) begin
         pm_word = 16'h2222;
      end else begin
         pmv[s] = int'($urandom_range(0, 7));
         for (int j = 0; j < 4; j++) begin
            if (j != int'(s)) begin
               v = int'($urandom_range(pmv[s], 15));
               if ((v == pmv[s]) && (j < int'(s))) v++;
               pmv[j] = v;
            end
         end
         pm_word = {4'(pmv[3]), 4'(pmv[2]), 4'(pmv[1]), 4'(pmv[0])};
      end
   endtask

   // Called and returns #1 after a rising edge.
   task automatic send_frame(input int n, input bit use_last, input logic [15:0] pm,
                             output int t_last);
      t_last = 0;
      for (int i = 0; i < n; i++) begin
         dec_valid = 1'b1;
         dec_bits  = dec_buf[i];
         dec_last  = use_last && (i == n - 1);
         final_pm  = pm;
         check("dec_ready_write", dec_ready, 1);
         t_last = cyc;
         @(posedge clock); #1;
      end
      dec_valid = 1'b0;
      dec_last  = 1'b0;
      dec_bits  = 4'h0;
      check("dec_ready_trace", dec_ready, 0);
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic collect(input int n_exp, input int stop_at, input int t_last, input int mode);
      int   got;
      int   budget;
      int   k;
      bit   first;
      bit   stalled;
      logic held;
      got = 0; budget = 0; k = 0; first = 1'b1; stalled = 1'b0; held = 1'b0;
      while ((got < stop_at) && (budget < 20 * FRAME_LEN + 50)) begin
         case (mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: bit_ready = 1'($urandom_range(0, 1));
         endcase
         k++;
         if (bit_valid) begin
            if (first) begin
               check("first_valid_latency", cyc - t_last, n_exp + 1);
               first = 1'b0;
            end
            check("dec_ready_output", dec_ready, 0);
            if (stalled) check("stall_hold", bit_out, held);
            if (bit_ready) begin
               check("bit_out", bit_out, exp_buf[got]);
               check("bit_last", bit_last, (got == n_exp - 1));
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = bit_out;
            end
         end else if (!first) begin
            check("valid_gap", bit_valid, 1);
         end
         @(posedge clock); #1;
         budget++;
      end
      bit_ready = 1'b0;
      check("bits_transferred", got, stop_at);
      if (stop_at == n_exp) begin
         check("idle_valid", bit_valid, 0);
         check("idle_ready", dec_ready, 1);
      end
   endtask

   initial begin
      int          t;
      int          n;
      bit          ul;
      logic [15:0] pm;

      n_vec = 0; n_err = 0;
      reset = 1'b1; dec_valid = 1'b0; dec_bits = 4'h0; dec_last = 1'b0;
      final_pm = '0; bit_ready = 1'b0;

      // encoder input 1,0,1,1 ending in state 3
      tbl[0] = '{n: 4, pm: 16'h0325, dec_word: 16'h0400, exp_bits: 4'b1101};
      // single step, best state 2
      tbl[1] = '{n: 1, pm: 16'h1011, dec_word: 16'h0000, exp_bits: 4'b0001};
      // single step, 0x0100 has the minimum (0) first at state 0
      tbl[2] = '{n: 1, pm: 16'h0100, dec_word: 16'h0000, exp_bits: 4'b0000};
      // two steps from state 2
      tbl[3] = '{n: 2, pm: 16'h5051, dec_word: 16'h00FF, exp_bits: 4'b0010};
      // three steps, all-zero metric at state 0
      tbl[4] = '{n: 3, pm: 16'hFFF0, dec_word: 16'h0120, exp_bits: 4'b0001};

      repeat (2) @(posedge clock);
      #1;
      check("rst_dec_ready", dec_ready, 1);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_bit_out", bit_out, 0);
      check("rst_bit_last", bit_last, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // table-driven frames
      for (int e = 0; e < 5; e++) begin
         load_entry(e);
         send_frame(tbl[e].n, 1'b1, tbl[e].pm, t);
         collect(tbl[e].n, tbl[e].n, t, e % 2);
      end

      // metric tie: traceback must start at state 0
      build_random(8, 1'b1, pm);
      send_frame(8, 1'b1, pm, t);
      collect(8, 8, t, 0);

      // forced close after FRAME_LEN vectors without dec_last
      build_random(FRAME_LEN, 1'b0, pm);
      send_frame(FRAME_LEN, 1'b0, pm, t);
      collect(FRAME_LEN, FRAME_LEN, t, 0);

      // backpressure
      build_random(8, 1'b0, pm);
      send_frame(8, 1'b1, pm, t);
      collect(8, 8, t, 1);

      // decisions offered during traceback are dropped and flagged
      load_entry(0);
      send_frame(4, 1'b1, tbl[0].pm, t);
      dec_valid = 1'b1; dec_bits = 4'hF; dec_last = 1'b1;
      check("overrun_before", overrun, 0);
      @(posedge clock); #1;
      check("overrun_pulse1", overrun, 1);
      @(posedge clock); #1;
      check("overrun_pulse2", overrun, 1);
      dec_valid = 1'b0; dec_bits = 4'h0; dec_last = 1'b0;
      @(posedge clock); #1;
      check("overrun_clear", overrun, 0);
      collect(4, 4, t, 0);

      // reset during output, then a single-step frame
      build_random(8, 1'b0, pm);
      send_frame(8, 1'b1, pm, t);
      collect(8, 2, t, 0);
      check("valid_before_reset", bit_valid, 1);
      reset = 1'b1;
      #1;
      check("reset_mid_valid", bit_valid, 0);
      check("reset_mid_ready", dec_ready, 1);
      check("reset_mid_last", bit_last, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      load_entry(1);
      send_frame(1, 1'b1, tbl[1].pm, t);
      collect(1, 1, t, 0);

      // random frames with random backpressure
      for (int f = 0; f < 20; f++) begin
         n  = int'($urandom_range(1, FRAME_LEN));
         ul = 1'b1;
         if (n == int'(FRAME_LEN)) ul = 1'($urandom_range(0, 1));
         build_random(n, 1'b0, pm);
         send_frame(n, ul, pm, t);
         collect(n, n, t, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
